decoder_3to8_strobe: RTL and testbench



---
 rtl/decoder_pkg.sv | 19 +
 rtl/strobe_timer.sv | 38 +++
 rtl/decoder_3to8_strobe.sv | 132 +++++++++++++
 tb/tb_decoder_3to8_strobe.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequential 3-to-8 strobe decoder.
package decoder_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_e;

  function automatic logic [7:0] onehot3to8(input logic [2:0] code);
    logic [7:0] r;
    r = '0;
    r[code] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/strobe_timer.sv
// Loadable down-counter shared by the hold and guard-gap phases.
module strobe_timer
  import decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear beats load beats decrement; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/decoder_3to8_strobe.sv
// Handshaked 3-to-8 decoder driving a timed one-hot strobe with a guard gap.
module decoder_3to8_strobe
  import decoder_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       e,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  output logic [7:0] y,
  output logic       busy,
  output logic       done
);

  if ((HOLD_CYCLES < 1) || (HOLD_CYCLES > 255)) begin : g_bad_hold
    $fatal(1, "HOLD_CYCLES must be in 1..255");
  end
  if (GAP_CYCLES > 255) begin : g_bad_gap
    $fatal(1, "GAP_CYCLES must be in 0..255");
  end

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] y_q, y_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [2:0] code_q, code_d;

  logic             tmr_clr, tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0] tmr_val;

  strobe_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  assign in_ready = (state_q == IDLE) && e;

  always_comb begin
    state_d  = state_q;
    y_d      = '0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    code_d   = code_q;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = HOLD_LD;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          code_d   = in_code;
          y_d      = onehot3to8(in_code);
          busy_d   = 1'b1;
          state_d  = DRIVE;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      DRIVE: begin
        // Enable loss aborts silently: no done pulse for a cut-short strobe.
        if (!e) begin
          busy_d  = 1'b0;
          state_d = IDLE;
          tmr_clr = 1'b1;
        end else if (!tmr_zero) begin
          y_d     = onehot3to8(code_q);
          tmr_dec = 1'b1;
        end else begin
          done_d = 1'b1;
          if (GAP_CYCLES == 0) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d  = GAP;
            tmr_load = 1'b1;
            tmr_val  = GAP_LD;
          end
        end
      end
      GAP: begin
        if (!e) begin
          busy_d  = 1'b0;
          state_d = IDLE;
          tmr_clr = 1'b1;
        end else if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        tmr_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      code_q  <= code_d;
    end
  end

  assign y    = y_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_decoder_3to8_strobe.sv
// Scoreboard bench: two instances (HOLD=4/GAP=1 and HOLD=2/GAP=0) share stimulus.
`timescale 1ns/1ps
module tb_decoder_3to8_strobe;
  import decoder_pkg::*;

  localparam int HA = 4, GA = 1;
  localparam int HB = 2, GB = 0;

  typedef struct packed {
    logic [7:0] y;
    logic       busy;
    logic       done;
    logic       rdy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       e, in_valid;
  logic [2:0] in_code;
  logic       rdy_a, busy_a, done_a, rdy_b, busy_b, done_b;
  logic [7:0] y_a, y_b;

  exp_t q_a[$], q_b[$];
  int   n_cmp = 0, n_fail = 0;
  int   edge_n = 0;
  int   acc_a = -1, acc_b = -1;
  logic [2:0] code_a = '0, code_b = '0;
  logic [7:0] tab [8];
  int   dones;

  always #5 clk = ~clk;

  decoder_3to8_strobe #(.HOLD_CYCLES(HA), .GAP_CYCLES(GA)) dut_a (
    .clk(clk), .rst_n(rst_n), .e(e), .in_valid(in_valid), .in_code(in_code),
    .in_ready(rdy_a), .y(y_a), .busy(busy_a), .done(done_a)
  );

  decoder_3to8_strobe #(.HOLD_CYCLES(HB), .GAP_CYCLES(GB)) dut_b (
    .clk(clk), .rst_n(rst_n), .e(e), .in_valid(in_valid), .in_code(in_code),
    .in_ready(rdy_b), .y(y_b), .busy(busy_b), .done(done_b)
  );

  // Timing model: strobe accepted at edge acc drives y after edges acc..acc+h-1,
  // pulses done after edge acc+h, and is idle from edge acc+h+g on.
  function automatic exp_t model_out(int acc, logic [2:0] code, int h, int g, int n, logic en);
    exp_t r;
    int   d;
    r = '0;
    if (acc >= 0) begin
      d      = n - acc;
      if (d < h) r.y = onehot3to8(code);
      r.done = (d == h);
      r.busy = (d < h + g);
    end
    r.rdy = en && !r.busy;
    return r;
  endfunction

  function automatic int next_acc(int acc, int h, int g, int n);
    logic idle;
    idle = (acc < 0) || ((n - 1) >= acc + h + g);
    if (!idle && !e) return -1;
    if (idle && e && in_valid) return n;
    return acc;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e_v, input logic v_v, input logic [2:0] c_v);
    int   na;
    exp_t ea, eb;
    e = e_v; in_valid = v_v; in_code = c_v;
    edge_n++;
    na = next_acc(acc_a, HA, GA, edge_n);
    if (na == edge_n) code_a = in_code;
    acc_a = na;
    na = next_acc(acc_b, HB, GB, edge_n);
    if (na == edge_n) code_b = in_code;
    acc_b = na;
    q_a.push_back(model_out(acc_a, code_a, HA, GA, edge_n, e));
    q_b.push_back(model_out(acc_b, code_b, HB, GB, edge_n, e));
    @(posedge clk);
    #1;
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    chk("A.y", y_a, ea.y);
    chk("A.busy", {7'd0, busy_a}, {7'd0, ea.busy});
    chk("A.done", {7'd0, done_a}, {7'd0, ea.done});
    chk("A.in_ready", {7'd0, rdy_a}, {7'd0, ea.rdy});
    chk("B.y", y_b, eb.y);
    chk("B.busy", {7'd0, busy_b}, {7'd0, eb.busy});
    chk("B.done", {7'd0, done_b}, {7'd0, eb.done});
    chk("B.in_ready", {7'd0, rdy_b}, {7'd0, eb.rdy});
  endtask

  initial begin
    tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    // 1: reset and idle
    rst_n = 1'b0; e = 1'b1; in_valid = 1'b0; in_code = '0;
    #1;
    chk("rst.y", y_a, 8'h00);
    chk("rst.busy", {7'd0, busy_a}, 8'h00);
    chk("rst.done", {7'd0, done_a}, 8'h00);
    chk("rst.in_ready", {7'd0, rdy_a}, 8'h01);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0);
    step(1, 0, 0);
    chk("idle.in_ready", {7'd0, rdy_a}, 8'h01);

    // 2: single strobe, code 5, on the HOLD=4/GAP=1 instance
    step(1, 1, 5);
    chk("T2.y_first", y_a, 8'h20);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 2);
      chk("T2.y_hold", y_a, 8'h20);
    end
    step(1, 0, 0);
    chk("T2.y_release", y_a, 8'h00);
    chk("T2.done", {7'd0, done_a}, 8'h01);
    chk("T2.ready_in_gap", {7'd0, rdy_a}, 8'h00);
    step(1, 0, 0);
    chk("T2.ready_after_gap", {7'd0, rdy_a}, 8'h01);

    // 3: back-to-back on the HOLD=2/GAP=0 instance, in_valid held
    dones = 0;
    begin
      logic [7:0] exp3 [6];
      logic [2:0] c3 [6];
      exp3 = '{8'h01, 8'h01, 8'h00, 8'h80, 8'h80, 8'h00};
      c3   = '{3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7};
      for (int i = 0; i < 6; i++) begin
        step(1, 1, c3[i]);
        chk("T3.y_seq", y_b, exp3[i]);
        if (done_b) dones++;
      end
    end
    chk("T3.done_count", 8'(dones), 8'd2);
    for (int i = 0; i < 8; i++) step(1, 0, 0);

    // 4: sweep every code
    for (int c = 0; c < 8; c++) begin
      step(1, 1, 3'(c));
      chk("T4.sweep", y_a, tab[c]);
      for (int i = 0; i < 5; i++) step(1, 0, 3'(7 - c));
    end

    // 5: abort by dropping e two cycles into a code-3 strobe
    step(1, 1, 3);
    chk("T5.y_start", y_a, 8'h08);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("T5.abort_y", y_a, 8'h00);
    chk("T5.abort_nodone", {7'd0, done_a}, 8'h00);
    chk("T5.abort_busy", {7'd0, busy_a}, 8'h00);
    step(0, 1, 2);
    chk("T5.blocked_ready", {7'd0, rdy_a}, 8'h00);
    chk("T5.blocked_y", y_a, 8'h00);
    step(1, 0, 0);
    chk("T5.ready_back", {7'd0, rdy_a}, 8'h01);
    step(1, 1, 2);
    chk("T5.reaccept", y_a, 8'h04);
    for (int i = 0; i < 5; i++) step(1, 0, 0);

    // 6: asynchronous reset in the middle of a code-6 strobe
    step(1, 1, 6);
    step(1, 0, 0);
    chk("T6.y_before", y_a, 8'h40);
    #2 rst_n = 1'b0;
    #1;
    chk("T6.y_async", y_a, 8'h00);
    chk("T6.busy_async", {7'd0, busy_a}, 8'h00);
    chk("T6.done_async", {7'd0, done_a}, 8'h00);
    chk("T6.yb_async", y_b, 8'h00);
    rst_n = 1'b1;
    acc_a = -1;
    acc_b = -1;
    step(1, 0, 0);
    chk("T6.idle_busy", {7'd0, busy_a}, 8'h00);
    chk("T6.idle_ready", {7'd0, rdy_a}, 8'h01);
    step(1, 1, 1);
    chk("T6.reaccept", y_a, 8'h02);
    for (int i = 0; i < 6; i++) step(1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
